kr580_port_uart: RTL and testbench

Serial I/O peripheral that answers the KR580 CPU's port bus: the CPU issues OUT/IN via `pa`/`po`/`pw`, and this block returns `pi` and drives the interrupt line. It holds a TX FIFO feeding an 8N1 serial transmitter, plus an optional receiver. It sits beside the 64 KB memory in the top level and connects directly to the CPU's port pins.

---
 rtl/kr580_port_uart_pkg.sv | 17 +
 rtl/kr580_port_uart_fifo.sv | 46 ++++
 rtl/kr580_port_uart.sv | 219 +++++++++++++++++++++
 tb/tb_kr580_port_uart.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/kr580_port_uart_pkg.sv
// Shared types and constants for the KR580 port-bus UART: TX/RX state enums,
// status register bit positions and port offsets relative to BASE.
package kr580_port_uart_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  localparam int unsigned ST_TX_FULL    = 0;
  localparam int unsigned ST_TX_EMPTY   = 1;
  localparam int unsigned ST_RX_READY   = 2;
  localparam int unsigned ST_RX_OVERRUN = 3;
  localparam int unsigned ST_IE         = 7;

  localparam logic [7:0] OFS_DATA = 8'd0;
  localparam logic [7:0] OFS_STAT = 8'd1;

endpackage

// File: rtl/kr580_port_uart_fifo.sv
// Synchronous byte FIFO, 2**DEPTH_LOG2 entries, head visible on dout with no
// read latency. Pointers carry an extra wrap bit to tell full from empty.
module kr580_port_uart_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  logic [7:0]          mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wp_q, wp_d, rp_q, rp_d;
  logic                do_push, do_pop;

  assign full  = (wp_q[DEPTH_LOG2-1:0] == rp_q[DEPTH_LOG2-1:0]) &&
                 (wp_q[DEPTH_LOG2] != rp_q[DEPTH_LOG2]);
  assign empty = (wp_q == rp_q);
  assign dout  = mem_q[rp_q[DEPTH_LOG2-1:0]];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wp_d    = wp_q + {{DEPTH_LOG2{1'b0}}, do_push};
    rp_d    = rp_q + {{DEPTH_LOG2{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/kr580_port_uart.sv
// KR580 port-bus UART: TX FIFO + 8N1 transmitter, status/control port, intr.
// Receiver is compiled in only when KR580_PORT_UART_RX_EN is defined.
module kr580_port_uart
  import kr580_port_uart_pkg::*;
#(
  parameter logic [7:0]  BASE       = 8'h40,
  parameter int unsigned DIVISOR    = 217,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pa,
  input  logic [7:0] po,
  input  logic       pw,
  output logic [7:0] pi,
  output logic       intr,
  output logic       tx,
  input  logic       rx
);

  localparam int unsigned BW        = $clog2(DIVISOR);
  localparam logic [BW-1:0] BAUD_MAX = BW'(DIVISOR - 1);
  localparam logic [7:0] DATA_ADDR  = BASE + OFS_DATA;
  localparam logic [7:0] STAT_ADDR  = BASE + OFS_STAT;

  logic       pw_q, pw_d, ie_q, ie_d, intr_q, intr_d;
  logic [7:0] pi_q, pi_d, status;
  logic       wr_stb, wr_data, wr_stat;
  logic       fifo_full, fifo_empty, tx_pop, tx_empty;
  logic [7:0] fifo_dout;
  logic [7:0] rx_data;
  logic       rx_ready, rx_overrun;

  tx_state_e  tx_state_q;
  logic       tx_q;
  logic [BW-1:0] tx_baud_q;
  logic [2:0] tx_bit_q;
  logic [7:0] tx_shift_q;

  assign wr_stb  = pw && !pw_q;
  assign wr_data = wr_stb && (pa == DATA_ADDR);
  assign wr_stat = wr_stb && (pa == STAT_ADDR);
  assign tx_pop  = (tx_state_q == TX_IDLE) && !fifo_empty;
  assign tx_empty = fifo_empty && (tx_state_q == TX_IDLE);

  kr580_port_uart_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (wr_data),
    .pop  (tx_pop),
    .din  (po),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = fifo_full;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_RX_READY]   = rx_ready;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_IE]         = ie_q;
    pw_d   = pw;
    ie_d   = wr_stat ? po[7] : ie_q;
    intr_d = ~(ie_q & (tx_empty | rx_ready));
    if (pa == DATA_ADDR)      pi_d = rx_data;
    else if (pa == STAT_ADDR) pi_d = status;
    else                      pi_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pw_q   <= 1'b0;
      ie_q   <= 1'b0;
      intr_q <= 1'b1;
      pi_q   <= '0;
    end else begin
      pw_q   <= pw_d;
      ie_q   <= ie_d;
      intr_q <= intr_d;
      pi_q   <= pi_d;
    end
  end

  // tx is registered alongside the state so each phase holds its level for
  // exactly DIVISOR cycles; the shifter is pre-shifted so tx_shift_q[1] is next.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: if (!fifo_empty) begin
          tx_shift_q <= fifo_dout;
          tx_q       <= 1'b0;
          tx_baud_q  <= BAUD_MAX;
          tx_state_q <= TX_START;
        end
        TX_START: if (tx_baud_q == '0) begin
          tx_baud_q  <= BAUD_MAX;
          tx_bit_q   <= '0;
          tx_q       <= tx_shift_q[0];
          tx_state_q <= TX_DATA;
        end else tx_baud_q <= tx_baud_q - 1'b1;
        TX_DATA: if (tx_baud_q == '0) begin
          tx_baud_q <= BAUD_MAX;
          if (tx_bit_q == 3'd7) begin
            tx_q       <= 1'b1;
            tx_state_q <= TX_STOP;
          end else begin
            tx_bit_q   <= tx_bit_q + 1'b1;
            tx_shift_q <= tx_shift_q >> 1;
            tx_q       <= tx_shift_q[1];
          end
        end else tx_baud_q <= tx_baud_q - 1'b1;
        TX_STOP: if (tx_baud_q == '0) tx_state_q <= TX_IDLE;
                 else tx_baud_q <= tx_baud_q - 1'b1;
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

`ifdef KR580_PORT_UART_RX_EN
  localparam logic [BW-1:0] HALF_MAX = BW'(DIVISOR / 2 - 1);

  rx_state_e     rx_state_q;
  logic          rx_s1_q, rx_s2_q, rx_s3_q, rx_valid_q;
  logic [BW-1:0] rx_baud_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_ready_q, rx_ready_d, rx_overrun_q, rx_overrun_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: if (rx_s3_q && !rx_s2_q) begin
          rx_baud_q  <= HALF_MAX;
          rx_state_q <= RX_START;
        end
        RX_START: if (rx_baud_q == '0) begin
          rx_baud_q  <= BAUD_MAX;
          rx_bit_q   <= '0;
          rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
        end else rx_baud_q <= rx_baud_q - 1'b1;
        RX_DATA: if (rx_baud_q == '0) begin
          rx_baud_q  <= BAUD_MAX;
          rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_q   <= rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
        end else rx_baud_q <= rx_baud_q - 1'b1;
        RX_STOP: if (rx_baud_q == '0) begin
          rx_valid_q <= rx_s2_q;
          rx_state_q <= RX_IDLE;
        end else rx_baud_q <= rx_baud_q - 1'b1;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_ready_d   = rx_ready_q;
    rx_overrun_d = rx_overrun_q;
    if (wr_stat && po[2]) rx_ready_d   = 1'b0;
    if (wr_stat && po[3]) rx_overrun_d = 1'b0;
    if (rx_valid_q) begin
      if (!rx_ready_q) begin
        rx_data_d  = rx_shift_q;
        rx_ready_d = 1'b1;
      end else rx_overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q    <= '0;
      rx_ready_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_data_q    <= rx_data_d;
      rx_ready_q   <= rx_ready_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_ready   = rx_ready_q;
  assign rx_overrun = rx_overrun_q;
`else
  logic unused_rx;
  assign unused_rx  = rx;
  assign rx_data    = '0;
  assign rx_ready   = 1'b0;
  assign rx_overrun = 1'b0;
`endif

  assign pi   = pi_q;
  assign intr = intr_q;
  assign tx   = tx_q;

endmodule

// File: tb/tb_kr580_port_uart.sv
// Self-checking bench for kr580_port_uart (DIVISOR=4, DEPTH_LOG2=4): a
// frame-level model of the TX line and status port, plus literal spot checks.
module tb_kr580_port_uart;

  localparam logic [7:0]  BASE  = 8'h40;
  localparam logic [7:0]  STAT  = 8'h41;
  localparam int unsigned DIV   = 4;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pa  = 8'h00;
  logic [7:0] po  = 8'h00;
  logic       pw  = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] pi;
  logic       intr, tx;

  int tests = 0;
  int fails = 0;

  kr580_port_uart #(.BASE(BASE), .DIVISOR(DIV), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .pa(pa), .po(po), .pw(pw),
    .pi(pi), .intr(intr), .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: bytes waiting in the FIFO, plus the frame on the wire described by
  // its byte and how many cycles have elapsed since its start bit began.
  logic [7:0] mq[$];
  logic [7:0] cur = '0;
  bit         busy = 0, ie_m = 0, pw_prev_m = 0;
  int unsigned cnt = 0;
  logic       exp_tx = 1'b1, exp_intr = 1'b1;
  logic [7:0] exp_pi = '0;
  bit         chk_en = 1;

  always @(posedge clk) begin
    logic [7:0] st;
    bit wr_m;
    int unsigned n_before, bi;
    if (rst) begin
      mq.delete(); busy = 0; cnt = 0; ie_m = 0; pw_prev_m = 0;
      exp_tx = 1'b1; exp_pi = '0; exp_intr = 1'b1;
    end else begin
      st = '0;
      st[0] = (mq.size() == DEPTH);
      st[1] = (mq.size() == 0) && !busy;
      st[7] = ie_m;
      exp_pi   = (pa == STAT) ? st : 8'h00;
      exp_intr = !(ie_m && st[1]);
      wr_m = pw && !pw_prev_m;
      pw_prev_m = pw;
      n_before = mq.size();
      if (!busy) begin
        if (mq.size() > 0) begin
          cur = mq.pop_front(); busy = 1; cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt == 10 * DIV) busy = 0;
      end
      if (wr_m && pa == BASE && n_before < DEPTH) mq.push_back(po);
      if (wr_m && pa == STAT) ie_m = po[7];
      bi = cnt / DIV;
      if (!busy)        exp_tx = 1'b1;
      else if (bi == 0) exp_tx = 1'b0;
      else if (bi == 9) exp_tx = 1'b1;
      else              exp_tx = cur[bi-1];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx", {7'b0, tx}, {7'b0, exp_tx});
      chk("pi", pi, exp_pi);
      chk("intr", {7'b0, intr}, {7'b0, exp_intr});
    end
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input int unsigned len);
    @(negedge clk); pa = a; po = d; pw = 1'b1;
    repeat (len) @(negedge clk);
    pw = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int unsigned bound);
    int unsigned n = 0;
    while ((mq.size() != 0 || busy) && n < bound) begin
      @(negedge clk); n++;
    end
    repeat (2) @(negedge clk);
    tests++;
    if (n >= bound) begin
      fails++;
      $display("FAIL %s: idle not reached within %0d cycles", nm, bound);
    end
  endtask

`ifdef KR580_PORT_UART_RX_EN
  task automatic send_rx(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rx = fr[i];
      repeat (DIV - 1) @(negedge clk);
    end
    repeat (3 * DIV) @(negedge clk);
  endtask
`endif

  initial begin
    logic [9:0] a5_wave;
    int unsigned n;
    bit hit;
    a5_wave = 10'b11_0100_1010;
    repeat (3) @(negedge clk);
    pa = STAT;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_status", pi, 8'h02);
    chk("reset_tx", {7'b0, tx}, 8'h01);
    chk("reset_intr", {7'b0, intr}, 8'h01);

    // 8'hA5 frame: tx falls two cycles after the pw edge, then the bit pattern
    @(negedge clk); pa = BASE; po = 8'hA5; pw = 1'b1;
    n = 0;
    while (tx !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    pw = 1'b0;
    chk("tx_fall_latency", 8'(n), 8'd2);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) @(negedge clk);
      else repeat (DIV) @(negedge clk);
      chk($sformatf("a5_bit%0d", i), {7'b0, tx}, {7'b0, a5_wave[i]});
    end
    wait_idle("a5_drain", 100);

    // 18 back-to-back writes: one enters the shifter, 16 fill the FIFO, one drops
    for (int i = 0; i < 18; i++) wr(BASE, 8'($urandom), 1);
    pa = STAT;
    @(negedge clk);
    chk("tx_full", pi & 8'h01, 8'h01);
    wait_idle("burst_drain", 18 * 11 * DIV + 100);

    // Long pw pulse: exactly one byte queued
    wr(BASE, 8'h5A, 8);
    pa = STAT;
    @(negedge clk);
    chk("long_pw_one_byte", 8'(mq.size() + (busy ? 1 : 0)), 8'd1);
    wait_idle("long_pw_drain", 100);

    // IE on with TX idle -> intr low, IE off -> intr high
    wr(STAT, 8'h80, 1);
    hit = 0;
    for (int i = 0; i < 2 && !hit; i++) begin
      @(negedge clk);
      if (intr === 1'b0) hit = 1;
    end
    chk("intr_assert", {7'b0, hit}, 8'h01);
    wr(STAT, 8'h00, 1);
    repeat (2) @(negedge clk);
    chk("intr_release", {7'b0, intr}, 8'h01);

    // Reset in mid-frame
    wr(BASE, 8'h00, 1);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midframe_reset_tx", {7'b0, tx}, 8'h01);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Randomised traffic
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0, 1: wr(BASE, 8'($urandom), $urandom_range(1, 3));
        2:    wr(STAT, 8'($urandom), $urandom_range(1, 3));
        default: begin
          @(negedge clk);
          case ($urandom_range(0, 2))
            0: pa = BASE;
            1: pa = STAT;
            default: pa = 8'($urandom);
          endcase
          repeat ($urandom_range(1, 20)) @(negedge clk);
        end
      endcase
    end
    wait_idle("random_drain", DEPTH * 11 * DIV + 200);

`ifdef KR580_PORT_UART_RX_EN
    chk_en = 0;
    wr(STAT, 8'h00, 1);
    send_rx(8'h3C);
    pa = BASE; repeat (2) @(negedge clk);
    chk("rx_data", pi, 8'h3C);
    pa = STAT; repeat (2) @(negedge clk);
    chk("rx_status_ready", pi, 8'h06);
    send_rx(8'hA1);
    repeat (2) @(negedge clk);
    chk("rx_status_overrun", pi, 8'h0E);
    pa = BASE; repeat (2) @(negedge clk);
    chk("rx_data_kept", pi, 8'h3C);
    wr(STAT, 8'h0C, 1);
    pa = STAT; repeat (3) @(negedge clk);
    chk("rx_status_cleared", pi, 8'h02);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
